// File: rtl/quadratic_pkg.sv
// Shared types and constants for the quadratic solver datapath and its serial readout.
package quadratic_pkg;

  localparam int unsigned ROOT_W    = 4;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Even parity over the payload: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/quad_baud_tick.sv
// Bit-period down-counter: tick_c is high for one cycle every CLKS_PER_BIT cycles.
module quad_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = (cnt_q == '0);

  // Restart aligns the first tick to the end of the start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else if (restart || tick_c) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/quadratic_root_tx.sv
// UART-style transmitter for the solver root pair {x2, x1}.
// Build option: define QUAD_TX_PARITY_EN to append an even-parity bit before stop.
module quadratic_root_tx
  import quadratic_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lock,
  input  logic [ROOT_W-1:0] x1_in,
  input  logic [ROOT_W-1:0] x2_in,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic                   tx_d, busy_d, done_d, overrun_d;
  logic                   restart_c;
  logic                   tick_c;
`ifdef QUAD_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  assign restart_c = (state_q == IDLE) && lock;

  quad_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    done_d    = 1'b0;
    overrun_d = lock && (state_q != IDLE);
`ifdef QUAD_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (lock) begin
          state_d  = START;
          shreg_d  = {x2_in, x1_in};
          bitcnt_d = '0;
`ifdef QUAD_TX_PARITY_EN
          parity_d = even_parity({x2_in, x1_in});
`endif
        end
      end
      START: begin
        if (tick_c) state_d = DATA;
      end
      DATA: begin
        if (tick_c) begin
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + BIT_CNT_W'(1);
          if (bitcnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef QUAD_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef QUAD_TX_PARITY_EN
      PARITY: begin
        if (tick_c) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level for the bit that the next state will be presenting.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef QUAD_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
      overrun  <= overrun_d;
    end
  end

`ifdef QUAD_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end
`endif

endmodule
